// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath widths, operation codes and opcode helpers used by the
// ALU result stage.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_OP_W   = 5;

  localparam logic [ALU_OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [ALU_OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [ALU_OP_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [ALU_OP_W-1:0] OP_SHRA = 5'b00110;
  localparam logic [ALU_OP_W-1:0] OP_SHL  = 5'b00111;
  localparam logic [ALU_OP_W-1:0] OP_ROR  = 5'b01000;
  localparam logic [ALU_OP_W-1:0] OP_ROL  = 5'b01001;
  localparam logic [ALU_OP_W-1:0] OP_AND  = 5'b01010;
  localparam logic [ALU_OP_W-1:0] OP_OR   = 5'b01011;
  localparam logic [ALU_OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [ALU_OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [ALU_OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [ALU_OP_W-1:0] OP_NOT  = 5'b10010;

  // Wide ops produce a result pair that is architecturally committed to HI/LO.
  function automatic logic is_wide(input logic [ALU_OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Generic DEPTH-entry register FIFO with push/pop handshakes, synchronous flush and
// occupancy count. The head output reads zero while the FIFO is empty.
module result_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;

  assign push_ready = (count_q != CntW'(DEPTH)) && reset_n;
  assign pop_valid  = (count_q != '0);
  assign pop_data   = pop_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

  assign push = push_valid && push_ready;
  assign pop  = pop_valid && pop_ready;

  always_comb begin
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result (Z) stage: buffers ALU result pairs, hands them to the bus with valid/ready and
// commits MUL/DIV results to HI/LO on pop. Optional zero/negative flags: ALU_RESULT_FLAGS_EN.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned OP_W   = ALU_OP_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        op_in,
  input  logic [DATA_W-1:0]      z_lo_in,
  input  logic [DATA_W-1:0]      z_hi_in,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_lo,
  output logic [DATA_W-1:0]      out_hi,
  output logic [OP_W-1:0]        out_op,
  output logic                   out_wide,
`ifdef ALU_RESULT_FLAGS_EN
  output logic                   flag_z,
  output logic                   flag_n,
`endif
  output logic [DATA_W-1:0]      hi_q,
  output logic [DATA_W-1:0]      lo_q,
  output logic [$clog2(DEPTH):0] count
);

`ifdef ALU_RESULT_FLAGS_EN
  localparam int unsigned FlagW = 2;
`else
  localparam int unsigned FlagW = 0;
`endif
  localparam int unsigned EntryW = FlagW + OP_W + 2 * DATA_W;

  logic [EntryW-1:0] push_data, pop_data;
  logic              commit;

`ifdef ALU_RESULT_FLAGS_EN
  logic in_wide, in_flag_z, in_flag_n;

  // Flags are computed once at push so the head outputs stay purely registered.
  always_comb begin
    in_wide   = is_wide(op_in);
    in_flag_z = in_wide ? ({z_hi_in, z_lo_in} == '0) : (z_lo_in == '0);
    in_flag_n = in_wide ? z_hi_in[DATA_W-1] : z_lo_in[DATA_W-1];
  end

  assign push_data = {in_flag_z, in_flag_n, op_in, z_hi_in, z_lo_in};
  assign flag_z    = pop_data[EntryW-1];
  assign flag_n    = pop_data[EntryW-2];
`else
  assign push_data = {op_in, z_hi_in, z_lo_in};
`endif

  result_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (push_data),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (pop_data),
    .count      (count)
  );

  assign out_lo   = pop_data[DATA_W-1:0];
  assign out_hi   = pop_data[2*DATA_W-1:DATA_W];
  assign out_op   = pop_data[2*DATA_W+OP_W-1:2*DATA_W];
  assign out_wide = is_wide(out_op);

  // A pop dropped by flush must not commit either.
  assign commit = out_valid && out_ready && !flush && out_wide;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= out_hi;
      lo_q <= out_lo;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_alu_result_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op_in = '0;
  logic [31:0] z_lo_in = '0;
  logic [31:0] z_hi_in = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_lo, out_hi, hi_q, lo_q;
  logic [4:0]  out_op;
  logic        out_wide;
  logic [1:0]  count;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] hi;
    logic [31:0] lo;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  alu_result_stage #(
    .DATA_W (32),
    .OP_W   (5),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_in     (op_in),
    .z_lo_in   (z_lo_in),
    .z_hi_in   (z_hi_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lo    (out_lo),
    .out_hi    (out_hi),
    .out_op    (out_op),
    .out_wide  (out_wide),
    .hi_q      (hi_q),
    .lo_q      (lo_q),
    .count     (count)
  );

  // Drive one cycle of inputs, advance one clock edge and update the reference model.
  task automatic cycle(input logic rn, input logic fl, input logic iv, input logic [4:0] op,
                       input logic [31:0] zh, input logic [31:0] zl, input logic ordy);
    ent_t e;
    bit   rdy_m, do_pop, do_push;
    reset_n = rn; flush = fl; in_valid = iv; op_in = op;
    z_hi_in = zh; z_lo_in = zl; out_ready = ordy;
    @(posedge clk);
    rdy_m = rn && (mq.size() != DEPTH);
    if (!rn) begin
      mq.delete();
      m_hi = '0;
      m_lo = '0;
    end else if (fl) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() != 0) && ordy;
      do_push = iv && rdy_m;
      if (do_pop) begin
        e = mq.pop_front();
        if (e.op == 5'b01111 || e.op == 5'b10000) begin
          m_hi = e.hi;
          m_lo = e.lo;
        end
      end
      if (do_push) mq.push_back('{op, zh, zl});
    end
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (out_valid !== 1'b0 || count !== 2'd0) begin
      n_fail++; $display("FAIL reset_state valid=%b count=%0d want 0/0", out_valid, count);
    end
    n_checks++;
    if (hi_q !== 32'd0 || lo_q !== 32'd0 || out_lo !== 32'd0 || out_op !== 5'd0 || out_wide !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs hi=%h lo=%h out_lo=%h out_op=%h wide=%b want zeros",
                         hi_q, lo_q, out_lo, out_op, out_wide);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add;
    cycle(1, 0, 1, 5'b00011, 32'd0, 32'd8, 1);
    n_checks++;
    if (out_valid !== 1'b1 || out_lo !== 32'd8 || out_wide !== 1'b0 || out_op !== 5'b00011) begin
      n_fail++; $display("FAIL add_head valid=%b lo=%0d wide=%b op=%h want 1/8/0/03",
                         out_valid, out_lo, out_wide, out_op);
    end
    cycle(1, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (out_valid !== 1'b0 || hi_q !== 32'd0 || lo_q !== 32'd0) begin
      n_fail++; $display("FAIL add_pop valid=%b hi=%h lo=%h want 0/0/0", out_valid, hi_q, lo_q);
    end
  endtask

  task automatic test_mul;
    cycle(1, 0, 1, 5'b01111, 32'd0, 32'd18, 1);
    n_checks++;
    if (out_wide !== 1'b1) begin n_fail++; $display("FAIL mul_wide got %b want 1", out_wide); end
    cycle(1, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (lo_q !== 32'd18 || hi_q !== 32'd0) begin
      n_fail++; $display("FAIL mul1_commit hi=%h lo=%h want 0/18", hi_q, lo_q);
    end
    cycle(1, 0, 1, 5'b01111, 32'h1, 32'h0, 1);
    cycle(1, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (hi_q !== 32'd1 || lo_q !== 32'd0) begin
      n_fail++; $display("FAIL mul2_commit hi=%h lo=%h want 1/0", hi_q, lo_q);
    end
  endtask

  task automatic test_div;
    cycle(1, 0, 1, 5'b10000, 32'd0, 32'd5, 1);
    cycle(1, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (hi_q !== 32'd0 || lo_q !== 32'd5) begin
      n_fail++; $display("FAIL div1_commit hi=%h lo=%h want 0/5", hi_q, lo_q);
    end
    cycle(1, 0, 1, 5'b10000, 32'd1, 32'd3, 1);
    cycle(1, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (hi_q !== 32'd1 || lo_q !== 32'd3) begin
      n_fail++; $display("FAIL div2_commit hi=%h lo=%h want 1/3", hi_q, lo_q);
    end
  endtask

  task automatic test_backpressure;
    cycle(1, 0, 1, 5'b00011, 32'd0, 32'd8, 0);
    cycle(1, 0, 1, 5'b00100, 32'd0, 32'd7, 0);
    in_valid = 1'b1; op_in = 5'b00011; z_lo_in = 32'd9;
    #1;
    n_checks++;
    if (count !== 2'd2 || in_ready !== 1'b0 || out_lo !== 32'd8) begin
      n_fail++; $display("FAIL bp_full count=%0d in_ready=%b head=%0d want 2/0/8", count, in_ready, out_lo);
    end
    cycle(1, 0, 1, 5'b00011, 32'd0, 32'd9, 0);
    n_checks++;
    if (count !== 2'd2 || out_lo !== 32'd8) begin
      n_fail++; $display("FAIL bp_hold count=%0d head=%0d want 2/8", count, out_lo);
    end
    cycle(1, 0, 1, 5'b00011, 32'd0, 32'd9, 1);
    n_checks++;
    if (count !== 2'd1 || out_lo !== 32'd7) begin
      n_fail++; $display("FAIL bp_pop1 count=%0d head=%0d want 1/7", count, out_lo);
    end
    cycle(1, 0, 1, 5'b00011, 32'd0, 32'd9, 1);
    n_checks++;
    if (count !== 2'd1 || out_lo !== 32'd9) begin
      n_fail++; $display("FAIL bp_pop2 count=%0d head=%0d want 1/9", count, out_lo);
    end
    cycle(1, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (out_valid !== 1'b0 || hi_q !== 32'd1 || lo_q !== 32'd3) begin
      n_fail++; $display("FAIL bp_drain valid=%b hi=%h lo=%h want 0/1/3", out_valid, hi_q, lo_q);
    end
  endtask

  task automatic test_flush;
    cycle(1, 0, 1, 5'b01111, 32'd2, 32'd3, 0);
    cycle(1, 0, 1, 5'b00011, 32'd0, 32'd4, 0);
    cycle(1, 1, 1, 5'b00011, 32'd0, 32'd5, 1);
    n_checks++;
    if (count !== 2'd0 || out_valid !== 1'b0 || hi_q !== 32'd1 || lo_q !== 32'd3) begin
      n_fail++; $display("FAIL flush_full count=%0d valid=%b hi=%h lo=%h want 0/0/1/3",
                         count, out_valid, hi_q, lo_q);
    end
    cycle(1, 0, 1, 5'b00011, 32'd0, 32'd6, 0);
    cycle(1, 1, 1, 5'b00011, 32'd0, 32'd7, 0);
    n_checks++;
    if (count !== 2'd0 || out_lo !== 32'd0) begin
      n_fail++; $display("FAIL flush_push_drop count=%0d head=%0d want 0/0", count, out_lo);
    end
  endtask

  task automatic test_reset_mid;
    cycle(1, 0, 1, 5'b01111, 32'd7, 32'd9, 0);
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_in_ready got %b want 0", in_ready); end
    cycle(0, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (hi_q !== 32'd0 || lo_q !== 32'd0 || count !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state hi=%h lo=%h count=%0d valid=%b want 0/0/0/0",
                         hi_q, lo_q, count, out_valid);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_release got %b want 1", in_ready); end
  endtask

  task automatic test_random;
    logic [4:0] ops [6];
    logic [4:0] op;
    logic       rn, exp_v, exp_w;
    logic [31:0] exp_lo, exp_hi;
    logic [4:0]  exp_op;
    ops[0] = 5'b01111; ops[1] = 5'b10000; ops[2] = 5'b00011;
    ops[3] = 5'b01010; ops[4] = 5'b10010; ops[5] = 5'b11111;
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : ops[$urandom_range(0, 5)];
      rn = ($urandom_range(0, 49) != 0);
      cycle(rn, ($urandom_range(0, 15) == 0), 1'($urandom), op, $urandom,
            ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, 1'($urandom));
      exp_v  = (mq.size() != 0);
      exp_lo = exp_v ? mq[0].lo : 32'd0;
      exp_hi = exp_v ? mq[0].hi : 32'd0;
      exp_op = exp_v ? mq[0].op : 5'd0;
      exp_w  = exp_v && (exp_op == 5'b01111 || exp_op == 5'b10000);
      n_checks++;
      if (count !== 2'(mq.size()) || out_valid !== exp_v) begin
        n_fail++; $display("FAIL rnd_occupancy i=%0d count=%0d valid=%b want %0d/%b",
                           i, count, out_valid, mq.size(), exp_v);
      end
      n_checks++;
      if (out_lo !== exp_lo || out_hi !== exp_hi || out_op !== exp_op || out_wide !== exp_w) begin
        n_fail++; $display("FAIL rnd_head i=%0d got %h/%h/%h/%b want %h/%h/%h/%b", i,
                           out_hi, out_lo, out_op, out_wide, exp_hi, exp_lo, exp_op, exp_w);
      end
      n_checks++;
      if (hi_q !== m_hi || lo_q !== m_lo) begin
        n_fail++; $display("FAIL rnd_hilo i=%0d got %h/%h want %h/%h", i, hi_q, lo_q, m_hi, m_lo);
      end
      n_checks++;
      if (in_ready !== (rn && (mq.size() != DEPTH))) begin
        n_fail++; $display("FAIL rnd_in_ready i=%0d got %b want %b", i, in_ready,
                           rn && (mq.size() != DEPTH));
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream neighbour of the ALU: captures each ALU result pair (Z_hi, Z_lo) with its 5-bit operation code into a small result buffer (the Z register stage).
- Presents results to the datapath bus with a valid/ready handshake.
- Commits multiply/divide results into the architectural HI and LO registers when they are consumed.
- Decouples the combinational ALU from bus/writeback stalls.

Parameters:
- DATA_W, 32, width of each result half (Z_hi, Z_lo, HI, LO).
- OP_W, 5, width of the ALU operation code.
- DEPTH, 2, number of buffer entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset; sampled on the clk rising edge.
- in_valid  in  1  ALU result on z_hi_in/z_lo_in/op_in is valid this cycle.
- in_ready  out  1  buffer can accept an entry this cycle.
- op_in  in  OP_W  ALU operation code that produced the result.
- z_lo_in  in  DATA_W  ALU low result; quotient for divide.
- z_hi_in  in  DATA_W  ALU high result; remainder for divide.
- flush  in  1  synchronous discard of all buffered entries.
- out_valid  out  1  head entry is available.
- out_ready  in  1  consumer accepts the head entry this cycle.
- out_lo  out  DATA_W  head entry low result.
- out_hi  out  DATA_W  head entry high result.
- out_op  out  OP_W  head entry operation code.
- out_wide  out  1  head op is MUL (5'b01111) or DIV (5'b10000).
- hi_q  out  DATA_W  architectural HI register.
- lo_q  out  DATA_W  architectural LO register.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Pointers and count go to 0; all buffered entries are discarded.
  - hi_q=0, lo_q=0; out_valid=0; out_lo/out_hi/out_op=0; out_wide=0.
  - in_ready=0 while reset_n is low; in_ready=1 in the first cycle after release.
- Reset mid-operation: in-flight entries are lost; no HI/LO commit happens in the reset cycle.
- Push: occurs when in_valid && in_ready. The entry is written at the write pointer; the write pointer wraps modulo DEPTH.
- in_ready = (count != DEPTH) && reset_n. There is no push-through-when-full; a full buffer deasserts in_ready even if out_ready=1.
- Pop: occurs when out_valid && out_ready. The read pointer wraps modulo DEPTH.
- Head outputs:
  - out_valid = (count != 0).
  - out_* reflect the entry at the read pointer, driven from registers (no combinational path from z_*_in).
  - When empty, out_lo/out_hi/out_op hold 0.
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N; one-cycle minimum. There is no empty-bypass.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- HI/LO commit, on pop only, in the same edge as the pop:
  - op MUL: hi_q<=out_hi, lo_q<=out_lo.
  - op DIV: lo_q<=out_lo (quotient), hi_q<=out_hi (remainder).
  - Any other op: HI/LO are unchanged.
- flush:
  - Pointers and count go to 0 at the edge.
  - flush has priority over push and pop; a push or pop in a flush cycle is dropped and no HI/LO commit occurs.
  - hi_q/lo_q are not affected by flush.
- Priority: reset_n > flush > push/pop.
- Operation codes not recognised are buffered and passed through unchanged, with out_wide=0.

Optional Feature:
- Macro ALU_RESULT_FLAGS_EN.
- Defined:
  - Adds outputs flag_z (out_lo==0) and flag_n (out_lo[DATA_W-1]), both registered with the entry at push.
  - For a wide op, flag_z = ({out_hi,out_lo}==0) and flag_n = out_hi[DATA_W-1].
  - Flags are 0 when empty and on reset.
- Not defined: flag ports are absent and no flag storage is built.

Decomposition:
- Shared package alu_pkg:
  - OP_W/DATA_W constants.
  - Opcode localparams: ADD 5'b00011, SUB 5'b00100, SHR 5'b00101, SHRA 5'b00110, SHL 5'b00111, ROR 5'b01000, ROL 5'b01001, AND 5'b01010, OR 5'b01011, MUL 5'b01111, DIV 5'b10000, NEG 5'b10001, NOT 5'b10010.
  - is_wide function.
- One sub-module, result_fifo: a generic DEPTH-entry register FIFO with push/pop/flush/count.
- alu_result_stage wraps result_fifo with the HI/LO commit logic and the optional flag logic.

Test Plan:
- ADD, op_in=5'b00011, z_lo_in=8, in_valid for 1 cycle, out_ready=1 → out_valid=1 one cycle later with out_lo=8, out_wide=0; popped the next edge; hi_q/lo_q stay 0.
- MUL, op 5'b01111, z_lo_in=18, z_hi_in=0 → out_wide=1; after pop, lo_q=18, hi_q=0. Then a MUL with z_hi_in=32'h1, z_lo_in=32'h0 → hi_q=1, lo_q=0.
- DIV, op 5'b10000, z_lo_in=5, z_hi_in=0, then op 5'b10000 with z_lo_in=3, z_hi_in=1 (10/3) → after the second pop, lo_q=3, hi_q=1.
- Backpressure: out_ready=0, push 2 entries (ADD 8, SUB 7) → count=2, in_ready=0, a third valid is held. Release out_ready → pops come out in order 8 then 7, and the third entry is accepted only after the first pop.
- flush with count=2 and simultaneous in_valid → count=0, out_valid=0 next cycle, pushed entry dropped, hi_q/lo_q unchanged.
- reset_n=0 for 1 cycle while holding a buffered MUL with out_ready=1 → no commit, hi_q=lo_q=0, count=0, in_ready=0 during reset and 1 the cycle after.
